// File: rtl/detector_secuencia_pkg.sv
// detector_secuencia_pkg
// Shared defaults and legal parameter limits for the parameterised serial
// pattern detector and its per-channel pulse stretcher.
// No ports; imported by detector_secuencia_param and pulse_stretcher.
package detector_secuencia_pkg;

  // Pattern length in bits
  localparam int W_DEFAULT         = 4;
  localparam int W_MIN             = 2;
  localparam int W_MAX             = 16;

  // Number of independent pattern channels
  localparam int NUM_PAT_DEFAULT   = 2;
  localparam int NUM_PAT_MIN       = 1;
  localparam int NUM_PAT_MAX       = 8;

  // 1 = overlapping matches allowed, 0 = restart detection after any match
  localparam int OVERLAP_DEFAULT   = 1;

  // Width of each saturating per-channel match counter
  localparam int CNT_WIDTH_DEFAULT = 8;

  // Cycles that led_hold stays high after a match
  localparam int HOLD_DEFAULT      = 4;
  localparam int HOLD_MIN          = 1;

  // Bits needed to hold a count that runs from 0 up to and including max_val
  function automatic int count_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/detector_secuencia_param_pulse_stretcher.sv
// pulse_stretcher
// Turns a single-cycle trigger into an indication that stays high for HOLD
// cycles, starting on the cycle after the trigger is sampled. A trigger that
// arrives while the output is already high reloads the timer to HOLD.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset, clears the timer
//   clear - synchronous clear of the timer
//   trig  - one-cycle request to (re)start the hold window
//   out   - stretched indication
module pulse_stretcher
  import detector_secuencia_pkg::*;
#(
  parameter int HOLD = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic trig,
  output logic out
);

  localparam int CW = count_bits(HOLD);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Timer next value: clear wins, a trigger reloads the full window, otherwise
  // count down to zero and rest there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (trig) begin
      cnt_d = CW'(HOLD);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Timer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The output is high for every cycle in which the timer holds HOLD..1,
  // which is exactly HOLD cycles after the last trigger.
  assign out = (cnt_q != '0);

endmodule

// File: rtl/detector_secuencia_param.sv
// detector_secuencia_param
// Serial pattern detector with NUM_PAT independent channels sharing a single
// shift history. Each channel compares the newest W-bit window against its
// own pattern, produces a one-cycle match pulse, a stretched match indication
// and a saturating match count.
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-low reset
//   entrada       - serial data bit
//   entrada_valid - entrada is sampled only when high
//   clear         - synchronous clear of history, fill, counters and timers
//   patron        - NUM_PAT patterns, channel k in [k*W +: W], MSB oldest
//   led           - one-cycle match pulse per channel
//   led_hold      - stretched match indication per channel
//   match_count   - saturating count per channel, [k*CNT_WIDTH +: CNT_WIDTH]
module detector_secuencia_param
  import detector_secuencia_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int NUM_PAT   = NUM_PAT_DEFAULT,
  parameter int OVERLAP   = OVERLAP_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int HOLD      = HOLD_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         entrada,
  input  logic                         entrada_valid,
  input  logic                         clear,
  input  logic [NUM_PAT*W-1:0]         patron,
  output logic [NUM_PAT-1:0]           led,
  output logic [NUM_PAT-1:0]           led_hold,
  output logic [NUM_PAT*CNT_WIDTH-1:0] match_count
);

  localparam int FW = count_bits(W);

  // Only the W-1 most recent bits need storing: the newest bit of the window
  // is always the incoming sample itself.
  logic [W-2:0]       hist_q;
  logic [W-2:0]       hist_d;
  logic [FW-1:0]      fill_q;
  logic [FW-1:0]      fill_d;
  logic [NUM_PAT-1:0] led_q;
  logic [NUM_PAT-1:0] led_d;

  logic [W-1:0]       window;
  logic               take_sample;
  logic               window_full;
  logic [NUM_PAT-1:0] match;
  logic               any_match;

  assign window      = {hist_q, entrada};
  assign take_sample = entrada_valid & ~clear;
  // This sample completes a full window when at least W-1 samples are
  // already held.
  assign window_full = (fill_q >= FW'(W - 1));
  assign any_match   = |match;

  // History and fill are shared by all channels. In non-overlap mode any match
  // empties the fill so a fresh W samples are needed before the next match.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (entrada_valid) begin
      hist_d = window[W-2:0];
      if (fill_q != FW'(W)) begin
        fill_d = fill_q + FW'(1);
      end
      if ((OVERLAP == 0) && any_match) begin
        fill_d = '0;
      end
    end
  end

  // The match pulse is registered so it appears on the cycle after the
  // matching sample; match is already suppressed by clear.
  always_comb begin
    led_d = match;
  end

  // Shared history, fill and pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      led_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

  // Per-channel comparator, saturating counter and pulse stretcher
  for (genvar k = 0; k < NUM_PAT; k++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign match[k] = take_sample & window_full &
                      (window == patron[k*W +: W]);

    // Count matches, holding at all-ones instead of wrapping
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (match[k] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    // Match counter register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign match_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

    pulse_stretcher #(
      .HOLD (HOLD)
    ) u_stretch (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .trig  (match[k]),
      .out   (led_hold[k])
    );
  end

endmodule

// File: tb/tb_detector_secuencia_param.sv
// tb_detector_secuencia_param
// Directed bench driving three detector variants from the same stimulus:
//   dut_a - defaults (OVERLAP=1, CNT_WIDTH=8)
//   dut_b - OVERLAP=0
//   dut_c - CNT_WIDTH=2 for saturation
// Patterns: channel 0 = 1011, channel 1 = 0110, HOLD = 4.
module tb_detector_secuencia_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entrada = 1'b0;
  logic       entrada_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] patron = 8'b0110_1011;

  logic [1:0]  a_led, a_hold, b_led, b_hold, c_led, c_hold;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  detector_secuencia_param #(.W(4), .NUM_PAT(2), .OVERLAP(1), .CNT_WIDTH(8), .HOLD(4)) dut_a (
    .clk(clk), .reset(reset), .entrada(entrada), .entrada_valid(entrada_valid),
    .clear(clear), .patron(patron), .led(a_led), .led_hold(a_hold), .match_count(a_cnt));

  detector_secuencia_param #(.W(4), .NUM_PAT(2), .OVERLAP(0), .CNT_WIDTH(8), .HOLD(4)) dut_b (
    .clk(clk), .reset(reset), .entrada(entrada), .entrada_valid(entrada_valid),
    .clear(clear), .patron(patron), .led(b_led), .led_hold(b_hold), .match_count(b_cnt));

  detector_secuencia_param #(.W(4), .NUM_PAT(2), .OVERLAP(1), .CNT_WIDTH(2), .HOLD(4)) dut_c (
    .clk(clk), .reset(reset), .entrada(entrada), .entrada_valid(entrada_valid),
    .clear(clear), .patron(patron), .led(c_led), .led_hold(c_hold), .match_count(c_cnt));

  // Drive one cycle of inputs, let the rising edge sample them, then settle
  // 1 time unit past the edge so outputs are read away from the clock.
  task automatic applyStimulus(input logic e, input logic v, input logic c);
    entrada       = e;
    entrada_valid = v;
    clear         = c;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int s1_bit[7]  = '{1, 0, 1, 1, 0, 1, 1};
    int s1_ledA[7] = '{0, 0, 0, 1, 2, 0, 1};
    int s1_ledB[7] = '{0, 0, 0, 1, 0, 0, 0};
    int s1_hldA[7] = '{0, 0, 0, 1, 3, 3, 3};
    int idle_hldA[4] = '{3, 1, 1, 0};
    int s4_e[7]    = '{1, 0, 1, 1, 1, 1, 1};
    int s4_v[7]    = '{1, 1, 0, 0, 0, 1, 1};
    int s4_led[7]  = '{0, 0, 0, 0, 0, 0, 1};
    logic [3:0] rep = 4'b1011;

    $display("[TB] start");

    // Reset held low: outputs stay zero even with valid data present
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("rst_led",   {a_led, b_led}, 32'h0);
      checkOutput("rst_hold",  {a_hold, b_hold}, 32'h0);
      checkOutput("rst_count", {a_cnt, b_cnt}, 32'h0);
    end
    reset = 1'b1;

    // Stream 1,0,1,1,0,1,1: overlap vs non-overlap behaviour
    for (int i = 0; i < 7; i++) begin
      applyStimulus(s1_bit[i][0], 1'b1, 1'b0);
      checkOutput($sformatf("s1_ledA_%0d", i + 1), {30'd0, a_led}, s1_ledA[i]);
      checkOutput($sformatf("s1_ledB_%0d", i + 1), {30'd0, b_led}, s1_ledB[i]);
      checkOutput($sformatf("s1_hldA_%0d", i + 1), {30'd0, a_hold}, s1_hldA[i]);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s1_idle_hldA_%0d", i), {30'd0, a_hold}, idle_hldA[i]);
      checkOutput($sformatf("s1_idle_ledA_%0d", i), {30'd0, a_led}, 32'h0);
    end
    checkOutput("s1_cntA0", {24'd0, a_cnt[7:0]},  32'd2);
    checkOutput("s1_cntA1", {24'd0, a_cnt[15:8]}, 32'd1);
    checkOutput("s1_cntB0", {24'd0, b_cnt[7:0]},  32'd1);
    checkOutput("s1_cntB1", {24'd0, b_cnt[15:8]}, 32'd0);

    // Clear together with a valid sample: sample discarded, counts zeroed
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clr_cntA", {16'd0, a_cnt}, 32'h0);
    checkOutput("clr_led",  {a_led, b_led}, 32'h0);

    // 1,0 then three invalid cycles then 1,1: single pulse after bit 4
    for (int i = 0; i < 7; i++) begin
      applyStimulus(s4_e[i][0], s4_v[i][0], 1'b0);
      checkOutput($sformatf("gap_ledA_%0d", i), {30'd0, a_led}, s4_led[i]);
      checkOutput($sformatf("gap_ledB_%0d", i), {30'd0, b_led}, s4_led[i]);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap_led_after", {30'd0, a_led}, 32'h0);
    checkOutput("gap_cntA0", {24'd0, a_cnt[7:0]}, 32'd1);

    // Five back-to-back 1011 matches: saturation and continuous hold
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(rep[3 - (i % 4)], 1'b1, 1'b0);
      checkOutput($sformatf("sat_hldC_%0d", i + 1), {31'd0, c_hold[0]}, (i >= 3) ? 32'd1 : 32'd0);
    end
    checkOutput("sat_cntC0", {30'd0, c_cnt[1:0]}, 32'd3);
    checkOutput("sat_cntC1", {30'd0, c_cnt[3:2]}, 32'd0);
    checkOutput("sat_cntA0", {24'd0, a_cnt[7:0]}, 32'd5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("sat_tail_hldC_%0d", i), {31'd0, c_hold[0]}, (i < 3) ? 32'd1 : 32'd0);
    end

    // Clear on the cycle of bit 4 suppresses the match
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clrb4_led",  {a_led, b_led}, 32'h0);
    checkOutput("clrb4_cnt",  {16'd0, a_cnt}, 32'h0);
    checkOutput("clrb4_hold", {a_hold, b_hold}, 32'h0);

    // Async reset after 1,0,1 discards history; 1 alone must not match
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("arst_cnt_low", {16'd0, a_cnt}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("arst_led",  {30'd0, a_led}, 32'h0);
    checkOutput("arst_cnt",  {16'd0, a_cnt}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("arst_rematch_led", {30'd0, a_led}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("arst_rematch_cnt", {24'd0, a_cnt[7:0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
